// File: rtl/axi4_read_stream_pkg.sv
// Shared types and constants for the DDR read-to-AXI4-Stream path.
// Threshold constant is only consumed when AXIS_RD_PROG_FULL_EN is defined.
package axi4_rd_stream_pkg;

  typedef enum logic {
    IDLE,
    INPKT
  } pkt_state_t;

  // Default prog_full threshold sits this many beats below DEPTH.
  localparam int unsigned PROG_FULL_MARGIN = 16;

  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/axi4_read_stream_sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO; head entry is presented combinationally.
module sync_fifo_fwft
  import axi4_rd_stream_pkg::*;
#(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned DEPTH  = 512
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      wr_en,
  input  logic                      rd_en,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      full,
  output logic                      empty,
  output logic [level_w(DEPTH)-1:0] level
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LVL_W = level_w(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [LVL_W-1:0]  wr_ptr;
  logic [LVL_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign level = wr_ptr - rd_ptr;

  assign push = wr_en && !full;
  assign pop  = rd_en && !empty;

  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + LVL_W'(1);
      if (pop)  rd_ptr <= rd_ptr + LVL_W'(1);
    end
  end

endmodule

// File: rtl/axi4_read_stream.sv
// DDR read beats -> FWFT FIFO -> AXI4-Stream master with per-packet TLAST and overflow accounting.
// Optional: define AXIS_RD_PROG_FULL_EN to add PROG_FULL_THRESH and the registered prog_full output.
module axi4_read_stream
  import axi4_rd_stream_pkg::*;
#(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned CNT_W  = 16
`ifdef AXIS_RD_PROG_FULL_EN
  ,
  parameter int unsigned PROG_FULL_THRESH = DEPTH - PROG_FULL_MARGIN
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         ddr_rd_data,
  input  logic                      ddr_rd_valid,
  input  logic [LEN_W-1:0]          cfg_pkt_beats,
  input  logic                      cfg_clr_err,
  output logic [DATA_W-1:0]         M_AXIS_TDATA,
  output logic [DATA_W/8-1:0]       M_AXIS_TKEEP,
  output logic                      M_AXIS_TVALID,
  output logic                      M_AXIS_TLAST,
  input  logic                      M_AXIS_TREADY,
  output logic                      overflow_err,
  output logic [CNT_W-1:0]          drop_count,
  output logic [level_w(DEPTH)-1:0] fifo_level,
`ifdef AXIS_RD_PROG_FULL_EN
  output logic                      prog_full,
`endif
  output logic [15:0]               latest_data_monitor
);

  localparam int unsigned LVL_W = level_w(DEPTH);

  logic             fifo_full;
  logic             fifo_empty;
  logic             drop;
  logic             pop;

  pkt_state_t       state, state_nxt;
  logic [LEN_W-1:0] beat_cnt, beat_cnt_nxt;
  logic [LEN_W-1:0] pkt_len, pkt_len_nxt;
  logic [LEN_W-1:0] eff_len;

  sync_fifo_fwft #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_data (ddr_rd_data),
    .wr_en   (ddr_rd_valid),
    .rd_en   (M_AXIS_TREADY),
    .rd_data (M_AXIS_TDATA),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign M_AXIS_TVALID       = !fifo_empty;
  assign M_AXIS_TKEEP        = '1;
  assign latest_data_monitor = M_AXIS_TDATA[15:0];

  assign drop = ddr_rd_valid && fifo_full;
  assign pop  = M_AXIS_TVALID && M_AXIS_TREADY;

  // A drop in the same cycle as a clear restarts the count at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_err <= 1'b0;
      drop_count   <= '0;
    end else if (drop) begin
      overflow_err <= 1'b1;
      if (cfg_clr_err) begin
        drop_count <= CNT_W'(1);
      end else if (drop_count != '1) begin
        drop_count <= drop_count + CNT_W'(1);
      end
    end else if (cfg_clr_err) begin
      overflow_err <= 1'b0;
      drop_count   <= '0;
    end
  end

  assign eff_len = (cfg_pkt_beats == '0) ? LEN_W'(1) : cfg_pkt_beats;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
      pkt_len  <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
      pkt_len  <= pkt_len_nxt;
    end
  end

  // The first beat of a packet is popped from IDLE, so INPKT starts at count 1.
  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    pkt_len_nxt  = pkt_len;
    M_AXIS_TLAST = 1'b0;
    unique case (state)
      IDLE: begin
        beat_cnt_nxt = '0;
        M_AXIS_TLAST = M_AXIS_TVALID && (eff_len == LEN_W'(1));
        if (pop && (eff_len != LEN_W'(1))) begin
          pkt_len_nxt  = eff_len;
          beat_cnt_nxt = LEN_W'(1);
          state_nxt    = INPKT;
        end
      end
      INPKT: begin
        M_AXIS_TLAST = M_AXIS_TVALID && (beat_cnt == pkt_len - LEN_W'(1));
        if (pop) begin
          if (M_AXIS_TLAST) begin
            beat_cnt_nxt = '0;
            state_nxt    = IDLE;
          end else begin
            beat_cnt_nxt = beat_cnt + LEN_W'(1);
          end
        end
      end
      default: begin
        state_nxt    = IDLE;
        beat_cnt_nxt = '0;
      end
    endcase
  end

`ifdef AXIS_RD_PROG_FULL_EN
  localparam logic [LVL_W-1:0] THRESH_L = LVL_W'(PROG_FULL_THRESH);

  always_ff @(posedge clk) begin
    if (rst) begin
      prog_full <= 1'b0;
    end else begin
      prog_full <= (fifo_level >= THRESH_L);
    end
  end
`endif

endmodule

// File: tb/tb_axi4_read_stream.sv
// Directed self-checking bench for axi4_read_stream (small FIFO, narrow counters).
module tb_axi4_read_stream;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] ddr_rd_data;
  logic              ddr_rd_valid;
  logic [LEN_W-1:0]  cfg_pkt_beats;
  logic              cfg_clr_err;
  logic [DATA_W-1:0] tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic              tvalid;
  logic              tlast;
  logic              tready;
  logic              overflow_err;
  logic [CNT_W-1:0]  drop_count;
  logic [3:0]        fifo_level;
  logic [15:0]       latest_data_monitor;

  int total;
  int bad;

  axi4_read_stream #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .LEN_W  (LEN_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .ddr_rd_data         (ddr_rd_data),
    .ddr_rd_valid        (ddr_rd_valid),
    .cfg_pkt_beats       (cfg_pkt_beats),
    .cfg_clr_err         (cfg_clr_err),
    .M_AXIS_TDATA        (tdata),
    .M_AXIS_TKEEP        (tkeep),
    .M_AXIS_TVALID       (tvalid),
    .M_AXIS_TLAST        (tlast),
    .M_AXIS_TREADY       (tready),
    .overflow_err        (overflow_err),
    .drop_count          (drop_count),
    .fifo_level          (fifo_level),
    .latest_data_monitor (latest_data_monitor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] drain_exp [8];
  logic        drain_last [8];

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; ddr_rd_data = '0; ddr_rd_valid = 1'b0;
    cfg_pkt_beats = 8'd4; cfg_clr_err = 1'b0; tready = 1'b1;
    step(); step();
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tlast", 64'(tlast), 64'd0);
    chk("rst_ovf", 64'(overflow_err), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("tkeep", 64'(tkeep), 64'hF);
    rst = 1'b0;
    step();

    // Packets of 4 with TREADY=1: each beat visible one cycle after its push.
    chk("t1_pre_tvalid", 64'(tvalid), 64'd0);
    for (int i = 0; i < 8; i++) begin
      ddr_rd_data = 32'(i); ddr_rd_valid = 1'b1;
      step();
      chk("t1_tvalid", 64'(tvalid), 64'd1);
      chk("t1_tdata", 64'(tdata), 64'(i));
      chk("t1_tlast", 64'(tlast), ((i % 4) == 3) ? 64'd1 : 64'd0);
      chk("t1_level", 64'(fifo_level), 64'd1);
    end
    ddr_rd_valid = 1'b0;
    step();
    chk("t1_end_tvalid", 64'(tvalid), 64'd0);
    chk("t1_end_tlast", 64'(tlast), 64'd0);

    // cfg_pkt_beats=0 behaves as single-beat packets.
    cfg_pkt_beats = 8'd0;
    for (int i = 0; i < 3; i++) begin
      ddr_rd_data = 32'hA0 + 32'(i); ddr_rd_valid = 1'b1;
      step();
      chk("t2_tdata", 64'(tdata), 64'hA0 + 64'(i));
      chk("t2_tlast", 64'(tlast), 64'd1);
      chk("t2_mon", 64'(latest_data_monitor), 64'hA0 + 64'(i));
    end
    ddr_rd_valid = 1'b0;
    step();
    chk("t2_end_tvalid", 64'(tvalid), 64'd0);

    // Overflow: 11 pushes into an 8-deep FIFO with TREADY=0.
    cfg_pkt_beats = 8'd4; tready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      ddr_rd_data = 32'h100 + 32'(i); ddr_rd_valid = 1'b1;
      step();
    end
    ddr_rd_valid = 1'b0;
    chk("t3_level", 64'(fifo_level), 64'd8);
    chk("t3_ovf", 64'(overflow_err), 64'd1);
    chk("t3_drop", 64'(drop_count), 64'd3);
    step();
    chk("t3_hold_tvalid", 64'(tvalid), 64'd1);
    chk("t3_hold_tdata", 64'(tdata), 64'h100);
    chk("t3_hold_tlast", 64'(tlast), 64'd0);
    tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t3_drain_tdata", 64'(tdata), 64'h100 + 64'(i));
      chk("t3_drain_tlast", 64'(tlast), (i == 3 || i == 7) ? 64'd1 : 64'd0);
      step();
    end
    chk("t3_empty_level", 64'(fifo_level), 64'd0);
    chk("t3_empty_tvalid", 64'(tvalid), 64'd0);

    cfg_clr_err = 1'b1;
    step();
    cfg_clr_err = 1'b0;
    chk("clr_ovf", 64'(overflow_err), 64'd0);
    chk("clr_drop", 64'(drop_count), 64'd0);

    // Full FIFO: push with a simultaneous pop is still dropped.
    tready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ddr_rd_data = 32'h200 + 32'(i); ddr_rd_valid = 1'b1;
      step();
    end
    chk("t4_full_level", 64'(fifo_level), 64'd8);
    ddr_rd_data = 32'h208; tready = 1'b1;
    step();
    chk("t4_pop_level", 64'(fifo_level), 64'd7);
    chk("t4_drop", 64'(drop_count), 64'd1);
    chk("t4_ovf", 64'(overflow_err), 64'd1);
    chk("t4_head", 64'(tdata), 64'h201);
    ddr_rd_data = 32'h209; tready = 1'b0;
    step();
    chk("t4_refill_level", 64'(fifo_level), 64'd8);
    chk("t4_refill_drop", 64'(drop_count), 64'd1);

    // Drop coinciding with clear: drop wins.
    ddr_rd_data = 32'h20A; cfg_clr_err = 1'b1;
    step();
    cfg_clr_err = 1'b0;
    chk("t5_ovf", 64'(overflow_err), 64'd1);
    chk("t5_drop", 64'(drop_count), 64'd1);
    for (int i = 0; i < 20; i++) step();
    ddr_rd_valid = 1'b0;
    chk("t5_sat", 64'(drop_count), 64'hF);
    cfg_clr_err = 1'b1;
    step();
    cfg_clr_err = 1'b0;
    chk("t5_clr_ovf", 64'(overflow_err), 64'd0);
    chk("t5_clr_drop", 64'(drop_count), 64'd0);

    // 0x200 already opened a packet, so its TLAST falls on 0x203.
    drain_exp = '{32'h201, 32'h202, 32'h203, 32'h204, 32'h205, 32'h206, 32'h207, 32'h209};
    drain_last = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t4_drain_tdata", 64'(tdata), 64'(drain_exp[i]));
      chk("t4_drain_tlast", 64'(tlast), 64'(drain_last[i]));
      step();
    end
    chk("t4_drain_level", 64'(fifo_level), 64'd0);

    // Reset mid-packet discards the remainder of the packet.
    rst = 1'b1;
    step();
    rst = 1'b0;
    tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ddr_rd_data = 32'h300 + 32'(i); ddr_rd_valid = 1'b1;
      step();
    end
    ddr_rd_valid = 1'b0; tready = 1'b1;
    step(); step();
    tready = 1'b0;
    chk("t6_pre_level", 64'(fifo_level), 64'd2);
    chk("t6_pre_tdata", 64'(tdata), 64'h302);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_tvalid", 64'(tvalid), 64'd0);
    chk("t6_rst_tlast", 64'(tlast), 64'd0);
    chk("t6_rst_level", 64'(fifo_level), 64'd0);
    tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ddr_rd_data = 32'h400 + 32'(i); ddr_rd_valid = 1'b1;
      step();
      chk("t6_tdata", 64'(tdata), 64'h400 + 64'(i));
      chk("t6_tlast", 64'(tlast), (i == 3) ? 64'd1 : 64'd0);
    end
    ddr_rd_valid = 1'b0;
    step();
    chk("t6_end_tvalid", 64'(tvalid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
